// File: rtl/alu_flag_cond_unit.sv
// Processor status register fed by the ALU flag outputs, plus a valid/ready
// condition evaluator for Bcond/Jcond/Scond. Optional macro: FLAG_FORWARD_EN.
module alu_flag_cond_unit #(
    parameter int WIDTH = 16,
    parameter int C_BIT = 0,
    parameter int L_BIT = 2,
    parameter int F_BIT = 5,
    parameter int Z_BIT = 6,
    parameter int N_BIT = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flag_we_i,
    input  logic [4:0]       flag_mask_i,
    input  logic             carry_i,
    input  logic             low_i,
    input  logic             overflow_i,
    input  logic             zero_i,
    input  logic             negative_i,
    input  logic             psr_load_i,
    input  logic [WIDTH-1:0] psr_load_data_i,
    output logic [WIDTH-1:0] psr_out_o,
    input  logic             cond_valid_i,
    input  logic [3:0]       cond_code_i,
    output logic             cond_ready_o,
    output logic             taken_valid_o,
    output logic             taken_o,
    input  logic             taken_ready_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] psr_q, psr_d;
    logic             taken_q, taken_d;

    logic [WIDTH-1:0] psr_flagged;
    logic [WIDTH-1:0] eval_psr;
    logic             accept;
    logic             cond_true;

    function automatic logic eval_cond(input logic [3:0] code, input logic [WIDTH-1:0] psr);
        logic c, l, f, z, n, res;
        c   = psr[C_BIT];
        l   = psr[L_BIT];
        f   = psr[F_BIT];
        z   = psr[Z_BIT];
        n   = psr[N_BIT];
        res = 1'b0;
        case (code)
            CC_EQ: res = z;
            CC_NE: res = !z;
            CC_CS: res = c;
            CC_CC: res = !c;
            CC_HI: res = l;
            CC_LS: res = !l;
            CC_GT: res = n;
            CC_LE: res = !n;
            CC_FS: res = f;
            CC_FC: res = !f;
            CC_LO: res = !l && !z;
            CC_HS: res = l || z;
            CC_LT: res = !n && !z;
            CC_GE: res = n || z;
            CC_UC: res = 1'b1;
            CC_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Mask order is {N,Z,F,L,C}; unmasked and non-flag bits keep their value.
    always_comb begin
        psr_flagged = psr_q;
        if (flag_mask_i[0]) psr_flagged[C_BIT] = carry_i;
        if (flag_mask_i[1]) psr_flagged[L_BIT] = low_i;
        if (flag_mask_i[2]) psr_flagged[F_BIT] = overflow_i;
        if (flag_mask_i[3]) psr_flagged[Z_BIT] = zero_i;
        if (flag_mask_i[4]) psr_flagged[N_BIT] = negative_i;
    end

    always_comb begin
        psr_d = psr_q;
        if (psr_load_i)
            psr_d = psr_load_data_i;
        else if (flag_we_i)
            psr_d = psr_flagged;
    end

`ifdef FLAG_FORWARD_EN
    // A restore load is never forwarded; only a flag capture is.
    assign eval_psr     = (flag_we_i && !psr_load_i) ? psr_flagged : psr_q;
    assign cond_ready_o = !taken_valid_o || taken_ready_i;
`else
    // Stall one cycle on a flag write so the query sees the updated PSR.
    assign eval_psr     = psr_q;
    assign cond_ready_o = (!taken_valid_o || taken_ready_i) && !flag_we_i;
`endif

    assign accept    = cond_valid_i && cond_ready_o;
    assign cond_true = eval_cond(cond_code_i, eval_psr);

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    taken_d = cond_true;
                end
            end
            RESP: begin
                if (taken_ready_i) begin
                    if (accept)
                        taken_d = cond_true;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            psr_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            taken_q <= taken_d;
        end
    end

    assign psr_out_o     = psr_q;
    assign taken_valid_o = (state_q == RESP);
    assign taken_o       = taken_q;

endmodule
